fpga_transmitter_param: RTL and testbench

- Parametrised, buffered serial transmitter for the FPGA-to-FPGA link.
- Host writes words into an internal FIFO.
- Block raises a request to the peer and waits for acknowledge. It then shifts each word out LSB-first at a programmable bit period, with an optional even-parity bit.
- Adds ack timeout/retry and a 4-phase release handshake.

---
 rtl/fpga_transmitter_param.sv | 172 +++++++++++++++++
 tb/tb_fpga_transmitter_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_transmitter_param.sv
// Buffered serial transmitter for the FPGA-to-FPGA link: host-side FIFO, request/acknowledge
// handshake with timeout/retry, LSB-first shifter with optional even parity.
module fpga_transmitter_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int BIT_CYCLES  = 4,
    parameter int PARITY_EN   = 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          load,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          sendToOther,
    input  logic                          acknowledge,
    output logic                          dataOut,
    output logic                          bitStart,
    output logic                          finish,
    output logic                          timeoutErr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, REQ, BACKOFF, SHIFT, PARITY, DONE} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [LW-1:0]         level_n;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] sreg, sreg_n;
    logic                  par, par_n;
    logic [TW-1:0]         tcnt, tcnt_n;
    logic [PW-1:0]         pcnt, pcnt_n;
    logic [BW-1:0]         bcnt, bcnt_n;
    logic                  fin_q;

    assign push   = load & ready;
    assign busy   = (state != IDLE) || (level != '0);
    assign finish = fin_q;

    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + LW'(1);
        else if (pop && !push)
            level_n = level - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wptr] <= dataIn;
    end

    // ready is registered from the next occupancy so it drops the cycle the FIFO fills
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ready <= 1'b1;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            level <= level_n;
            ready <= (level_n != LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            par   <= 1'b0;
            tcnt  <= '0;
            pcnt  <= '0;
            bcnt  <= '0;
            fin_q <= 1'b0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            par   <= par_n;
            tcnt  <= tcnt_n;
            pcnt  <= pcnt_n;
            bcnt  <= bcnt_n;
            fin_q <= (state_n == DONE) && (state != DONE);
        end
    end

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        par_n       = par;
        tcnt_n      = tcnt;
        pcnt_n      = pcnt;
        bcnt_n      = bcnt;
        pop         = 1'b0;
        sendToOther = 1'b0;
        dataOut     = 1'b1;
        bitStart    = 1'b0;
        timeoutErr  = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    sreg_n  = mem[rptr];
                    par_n   = ^mem[rptr];
                    tcnt_n  = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                sendToOther = 1'b1;
                if (acknowledge) begin
                    pcnt_n  = '0;
                    bcnt_n  = '0;
                    state_n = SHIFT;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    timeoutErr = 1'b1;
                    state_n    = BACKOFF;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            BACKOFF: begin
                tcnt_n  = '0;
                state_n = REQ;
            end
            SHIFT: begin
                sendToOther = 1'b1;
                dataOut     = sreg[0];
                bitStart    = (pcnt == '0);
                if (pcnt == PW'(BIT_CYCLES - 1)) begin
                    pcnt_n = '0;
                    sreg_n = sreg >> 1;
                    bcnt_n = bcnt + BW'(1);
                    if (bcnt == BW'(DATA_WIDTH - 1))
                        state_n = (PARITY_EN != 0) ? PARITY : DONE;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            PARITY: begin
                sendToOther = 1'b1;
                dataOut     = par;
                bitStart    = (pcnt == '0);
                if (pcnt == PW'(BIT_CYCLES - 1)) begin
                    pcnt_n  = '0;
                    state_n = DONE;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            DONE: begin
                // Four-phase release: the peer must drop acknowledge before any new request
                if (!acknowledge)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpga_transmitter_param.sv
// Bench for fpga_transmitter_param: default 8/4/4/1/16 instance plus a 12-bit, no-parity,
// one-clock-per-bit instance, checked against a queue-based serial frame model.
module tb_fpga_transmitter_param;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int BC = 4;
    localparam int PE = 1;
    localparam int TO = 16;
    localparam int DWB = 12;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_a = 1'b1, load_a = 1'b0, ack_a = 1'b0;
    logic [DW-1:0] din_a = '0;
    logic          ready_a, busy_a, send_a, dout_a, bs_a, fin_a, to_a;
    logic [2:0]    level_a;

    logic           reset_b = 1'b1, load_b = 1'b0, ack_b = 1'b0;
    logic [DWB-1:0] din_b = '0;
    logic           ready_b, busy_b, send_b, dout_b, bs_b, fin_b, to_b;
    logic [2:0]     level_b;

    int vectors = 0;
    int miscompares = 0;

    fpga_transmitter_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BIT_CYCLES(BC),
                             .PARITY_EN(PE), .ACK_TIMEOUT(TO)) dut_a (
        .clock(clock), .reset(reset_a), .dataIn(din_a), .load(load_a), .ready(ready_a),
        .level(level_a), .busy(busy_a), .sendToOther(send_a), .acknowledge(ack_a),
        .dataOut(dout_a), .bitStart(bs_a), .finish(fin_a), .timeoutErr(to_a));

    fpga_transmitter_param #(.DATA_WIDTH(DWB), .FIFO_DEPTH(4), .BIT_CYCLES(1),
                             .PARITY_EN(0), .ACK_TIMEOUT(16)) dut_b (
        .clock(clock), .reset(reset_b), .dataIn(din_b), .load(load_b), .ready(ready_b),
        .level(level_b), .busy(busy_b), .sendToOther(send_b), .acknowledge(ack_b),
        .dataOut(dout_b), .bitStart(bs_b), .finish(fin_b), .timeoutErr(to_b));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Follows one frame of DUT A from its first bitStart through DONE entry.
    task automatic collect_a(input logic [DW-1:0] w);
        logic q[$];
        logic [3:0] got, exp;
        int n = 0;
        while (bs_a !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        vectors++;
        if (bs_a !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_start word=%h got bitStart=%b exp=1 within 64 clocks", w, bs_a);
            return;
        end
        for (int b = 0; b < DW + PE; b++)
            for (int c = 0; c < BC; c++)
                q.push_back((b < DW) ? w[b] : ^w);
        for (int j = 0; j < q.size(); j++) begin
            if (j > 0) step();
            got = {send_a, dout_a, bs_a, fin_a};
            exp = {1'b1, q[j], (j % BC) == 0, 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL frame_bit word=%h cycle=%0d got=%b exp=%b", w, j, got, exp);
            end
            ack_a = (j == q.size() - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        step();
        got = {send_a, dout_a, bs_a, fin_a};
        vectors++;
        if (got !== 4'b0101) begin
            miscompares++;
            $display("FAIL done_entry word=%h got=%b exp=0101", w, got);
        end
    endtask

    // Holds acknowledge in DONE, drops it, and checks the request restarts two clocks later.
    task automatic release_a(input int hold, input logic exp_req);
        logic [4:0] got;
        for (int h = 0; h < hold; h++) begin
            step();
            got = {send_a, dout_a, fin_a, bs_a, busy_a};
            vectors++;
            if (got !== 5'b01001) begin
                miscompares++;
                $display("FAIL done_hold cycle=%0d got=%b exp=01001", h, got);
            end
        end
        ack_a = 1'b0;
        step();
        vectors++;
        if (send_a !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_gap got=%b exp=0", send_a);
        end
        step();
        vectors++;
        if (send_a !== exp_req) begin
            miscompares++;
            $display("FAIL req_after_release got=%b exp=%b", send_a, exp_req);
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset_a = 1'b1;
        reset_b = 1'b1;
        step();
        step();
        got = {send_a, dout_a, bs_a, fin_a, to_a, ready_a, busy_a};
        vectors++;
        if (got !== 7'b0100010 || level_a !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_a got=%b level=%0d exp=0100010 level=0", got, level_a);
        end
        got = {send_b, dout_b, bs_b, fin_b, to_b, ready_b, busy_b};
        vectors++;
        if (got !== 7'b0100010 || level_b !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_b got=%b level=%0d exp=0100010 level=0", got, level_b);
        end
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();
    endtask

    task automatic test_frame(input logic [DW-1:0] w, input int d);
        din_a = w;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        vectors++;
        if (send_a !== 1'b0) begin
            miscompares++;
            $display("FAIL req_early word=%h got=%b exp=0", w, send_a);
        end
        step();
        vectors++;
        if ({send_a, dout_a} !== 2'b11) begin
            miscompares++;
            $display("FAIL req_latency word=%h got=%b exp=11", w, {send_a, dout_a});
        end
        for (int k = 0; k < d; k++) begin
            step();
            vectors++;
            if ({send_a, dout_a, to_a} !== 3'b110) begin
                miscompares++;
                $display("FAIL req_wait word=%h k=%0d got=%b exp=110", w, k, {send_a, dout_a, to_a});
            end
        end
        ack_a = 1'b1;
        step();
        vectors++;
        if (bs_a !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_start word=%h got=%b exp=1", w, bs_a);
        end
        collect_a(w);
        release_a($urandom_range(0, 3), 1'b0);
    endtask

    task automatic test_fill();
        logic [DW-1:0] exp_q[$];
        for (int i = 1; i <= 6; i++) begin
            din_a = DW'(i);
            load_a = 1'b1;
            if (i <= FD + 1) exp_q.push_back(DW'(i));
            step();
        end
        load_a = 1'b0;
        vectors++;
        if ({ready_a, level_a} !== {1'b0, 3'(FD)}) begin
            miscompares++;
            $display("FAIL fifo_full got ready=%b level=%0d exp ready=0 level=%0d", ready_a, level_a, FD);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) release_a($urandom_range(1, 4), 1'b1);
            ack_a = 1'b1;
            collect_a(exp_q[k]);
        end
        release_a($urandom_range(0, 2), 1'b0);
    endtask

    task automatic test_timeout(input logic [DW-1:0] w);
        din_a = w;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        step();
        for (int k = 1; k <= TO; k++) begin
            vectors++;
            if ({send_a, to_a} !== {1'b1, k == TO}) begin
                miscompares++;
                $display("FAIL req_timeout k=%0d got=%b exp=%b", k, {send_a, to_a}, {1'b1, k == TO});
            end
            if (k < TO) step();
        end
        step();
        vectors++;
        if ({send_a, to_a} !== 2'b00) begin
            miscompares++;
            $display("FAIL backoff got=%b exp=00", {send_a, to_a});
        end
        step();
        vectors++;
        if (send_a !== 1'b1) begin
            miscompares++;
            $display("FAIL retry_req got=%b exp=1", send_a);
        end
        ack_a = 1'b1;
        step();
        collect_a(w);
        release_a($urandom_range(0, 2), 1'b0);
    endtask

    task automatic test_reset_mid(input logic [DW-1:0] w);
        logic [6:0] got;
        for (int i = 0; i < 3; i++) begin
            din_a = (i == 0) ? w : DW'($urandom);
            load_a = 1'b1;
            step();
        end
        load_a = 1'b0;
        ack_a = 1'b1;
        step();
        for (int c = 0; c < 3 * BC + int'($urandom_range(0, BC - 1)); c++)
            step();
        vectors++;
        if (dout_a !== w[3]) begin
            miscompares++;
            $display("FAIL bit3_pre_reset got=%b exp=%b", dout_a, w[3]);
        end
        reset_a = 1'b1;
        ack_a = 1'b0;
        step();
        got = {send_a, dout_a, bs_a, fin_a, to_a, ready_a, busy_a};
        vectors++;
        if (got !== 7'b0100010 || level_a !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid got=%b level=%0d exp=0100010 level=0", got, level_a);
        end
        reset_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors++;
            if ({send_a, fin_a, busy_a} !== 3'b000) begin
                miscompares++;
                $display("FAIL post_reset_quiet c=%0d got=%b exp=000", c, {send_a, fin_a, busy_a});
            end
        end
    endtask

    task automatic test_wide(input logic [DWB-1:0] w);
        logic [3:0] got;
        din_b = w;
        load_b = 1'b1;
        step();
        load_b = 1'b0;
        step();
        vectors++;
        if (send_b !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_req got=%b exp=1", send_b);
        end
        ack_b = 1'b1;
        step();
        for (int j = 0; j < DWB; j++) begin
            if (j > 0) step();
            got = {send_b, dout_b, bs_b, fin_b};
            vectors++;
            if (got !== {1'b1, w[j], 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL wide_bit word=%h j=%0d got=%b exp=%b", w, j, got, {1'b1, w[j], 2'b10});
            end
        end
        step();
        got = {send_b, dout_b, bs_b, fin_b};
        vectors++;
        if (got !== 4'b0101) begin
            miscompares++;
            $display("FAIL wide_done word=%h got=%b exp=0101", w, got);
        end
        ack_b = 1'b0;
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_frame(8'hA5, 3);
        for (int i = 0; i < 6; i++)
            test_frame(DW'($urandom), $urandom_range(0, 12));
        test_fill();
        test_timeout(DW'($urandom));
        test_reset_mid(DW'($urandom));
        test_frame(DW'($urandom), 1);
        test_wide(12'hFFF);
        test_wide(DWB'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
